// File: rtl/stream_accum_pkg.sv
// Shared types and default constants for the stream accumulator.
package stream_accum_pkg;

    // Controller state: collecting a group, or presenting its sum.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 4;

endpackage

// File: rtl/stream_accum_if.sv
// Input and output valid/ready streams of the accumulator.
// Producer/consumer side uses master; the accumulator uses slave.
interface stream_accum_if
    import stream_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );

endinterface

// File: rtl/stream_accum_mod_n_counter.sv
// Modulo-N element counter; wrap flags the increment that closes a group.
module mod_n_counter #(
    parameter int N = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 inc,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] count,
    output logic                                 wrap
);

    localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    logic [CNT_W-1:0] r_count;

    assign wrap  = inc && (r_count == LAST);
    assign count = r_count;

    // Count accepted elements, returning to zero after the last one of a group.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_accum.sv
// Sums groups of N unsigned values (mod 2^WIDTH) from a valid/ready stream
// and presents each group sum on a second valid/ready stream.
module stream_accum
    import stream_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    stream_accum_if.slave bus
);

    localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_wrap;
    logic [CNT_W-1:0] w_count;
    logic [WIDTH-1:0] w_acc_next;

    // Handshakes are qualified by the registered state, never by outputs of
    // combinational logic, so no input-to-output path exists.
    assign w_in_xfer  = (r_state == ACCUM) && bus.in_valid;
    assign w_out_xfer = (r_state == HOLD) && bus.out_ready;
    assign w_acc_next = r_acc + bus.in_data;

    mod_n_counter #(
        .N (N)
    ) u_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (w_in_xfer),
        .count (w_count),
        .wrap  (w_wrap)
    );

    // FSM plus accumulator: reset beats clear, clear beats any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_sum   <= '0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_in_xfer) begin
                        if (w_wrap) begin
                            r_sum   <= w_acc_next;
                            r_acc   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_acc <= w_acc_next;
                        end
                    end
                end
                HOLD: begin
                    if (w_out_xfer) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_sum   = r_sum;

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) w_count <= LAST_CNT);

endmodule

// File: tb/tb_stream_accum.sv
// Bench for stream_accum: directed scenarios plus randomized traffic on the
// default configuration, and short checks on two other parameter sets.
module tb_stream_accum;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    always #5 clk = ~clk;

    stream_accum_if #(.WIDTH(8))  if0 ();
    stream_accum_if #(.WIDTH(16)) if1 ();
    stream_accum_if #(.WIDTH(4))  if2 ();

    stream_accum #(.WIDTH(8), .N(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0.slave)
    );
    stream_accum #(.WIDTH(16), .N(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1.slave)
    );
    stream_accum #(.WIDTH(4), .N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference for dut0: expected group behaviour in plain integers.
    bit m_hold   = 1'b0;
    int m_cnt    = 0;
    int m_acc    = 0;
    int m_sum    = 0;
    bit m_sumchk = 1'b0;
    int dut_groups = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of dut0 traffic: drive, check against reference, advance reference.
    task automatic cycle(input bit rn, input bit cl, input bit iv,
                         input logic [7:0] d, input bit ordy);
        rst_n        = rn;
        clear        = cl;
        if0.in_valid = iv;
        if0.in_data  = d;
        if0.out_ready = ordy;
        @(negedge clk);
        chk("out_valid", if0.out_valid, m_hold);
        chk("in_ready", if0.in_ready, !m_hold);
        if (m_sumchk) chk("out_sum", if0.out_sum, m_sum);
        if (if0.out_valid && ordy && rn && !cl) dut_groups++;
        if (!rn) begin
            m_hold = 0; m_cnt = 0; m_acc = 0; m_sum = 0; m_sumchk = 1;
        end else if (cl) begin
            m_hold = 0; m_cnt = 0; m_acc = 0; m_sumchk = 0;
        end else if (!m_hold) begin
            if (iv) begin
                m_acc = (m_acc + int'(d)) % 256;
                m_cnt++;
                if (m_cnt == 4) begin
                    m_hold = 1; m_sum = m_acc; m_sumchk = 1;
                    m_acc = 0; m_cnt = 0;
                end
            end
        end else if (ordy) begin
            m_hold = 0; m_sumchk = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic group4(input int a, input int b, input int c, input int d, input bit ordy);
        cycle(1, 0, 1, 8'(a), ordy);
        cycle(1, 0, 1, 8'(b), ordy);
        cycle(1, 0, 1, 8'(c), ordy);
        cycle(1, 0, 1, 8'(d), ordy);
    endtask

    initial begin
        int g0;
        int ref_sum;
        logic [15:0] v16;
        logic [3:0]  v4;

        rst_n = 1'b0; clear = 1'b0;
        if0.in_valid = 0; if0.in_data = '0; if0.out_ready = 0;
        if1.in_valid = 0; if1.in_data = '0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_data = '0; if2.out_ready = 1;
        @(posedge clk); #1;

        // Reset state
        cycle(0, 0, 1, 8'd77, 1);
        chk("rst_in_ready", if0.in_ready, 1);
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_sum", if0.out_sum, 0);

        // Basic group, valid exactly one cycle after 4th transfer
        group4(10, 20, 30, 40, 1);
        chk("basic_vld", if0.out_valid, 1);
        chk("basic_sum", if0.out_sum, 100);
        cycle(1, 0, 0, 8'd0, 1);
        chk("basic_vld_drop", if0.out_valid, 0);

        // Wrap-around
        group4(200, 150, 100, 50, 1);
        chk("wrap_sum_a", if0.out_sum, 244);
        cycle(1, 0, 0, 8'd0, 1);
        group4(255, 255, 255, 255, 1);
        chk("wrap_sum_b", if0.out_sum, 252);
        cycle(1, 0, 0, 8'd0, 1);

        // Backpressure: 5 stalled cycles with input offered
        group4(1, 2, 3, 4, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 1, 8'($urandom), 0);
            chk("bp_in_ready", if0.in_ready, 0);
            chk("bp_sum", if0.out_sum, 10);
        end
        cycle(1, 0, 1, 8'd9, 1);
        chk("bp_release", if0.in_ready, 1);

        // Input gaps
        for (int v = 1; v <= 4; v++) begin
            cycle(1, 0, 1, 8'(v), 1);
            if (v != 4) begin
                cycle(1, 0, 0, 8'($urandom), 1);
                cycle(1, 0, 0, 8'($urandom), 1);
            end
        end
        chk("gap_sum", if0.out_sum, 10);
        cycle(1, 0, 0, 8'd0, 1);

        // Clear after 2 inputs, coinciding with a transfer
        cycle(1, 0, 1, 8'd7, 1);
        cycle(1, 0, 1, 8'd9, 1);
        cycle(1, 1, 1, 8'd99, 1);
        group4(5, 5, 5, 5, 1);
        chk("clear_sum", if0.out_sum, 20);
        cycle(1, 0, 0, 8'd0, 1);

        // Same sequence with reset instead of clear
        cycle(1, 0, 1, 8'd7, 1);
        cycle(1, 0, 1, 8'd9, 1);
        cycle(0, 0, 1, 8'd99, 1);
        chk("rst2_in_ready", if0.in_ready, 1);
        chk("rst2_out_valid", if0.out_valid, 0);
        chk("rst2_out_sum", if0.out_sum, 0);
        group4(5, 5, 5, 5, 1);
        chk("rst2_sum", if0.out_sum, 20);
        cycle(1, 0, 0, 8'd0, 1);

        // Clear while holding a result
        group4(3, 3, 3, 3, 0);
        cycle(1, 1, 0, 8'd0, 1);
        chk("clear_hold_vld", if0.out_valid, 0);

        // Throughput: one group per N+1 cycles under full streaming
        g0 = dut_groups;
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 8'($urandom), 1);
        chk("throughput", dut_groups - g0, 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom));
        end
        if0.in_valid = 0;

        // WIDTH=16, N=8
        rst_n = 0; @(posedge clk); #1; rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            if1.in_valid = 1; if1.in_data = 16'(1000 + 100 * i);
            @(posedge clk); #1;
        end
        if1.in_valid = 0;
        chk("w16_vld", if1.out_valid, 1);
        chk("w16_sum", if1.out_sum, 10800);
        @(posedge clk); #1;
        ref_sum = 0;
        for (int i = 0; i < 8; i++) begin
            v16 = 16'($urandom);
            ref_sum = (ref_sum + int'(v16)) % 65536;
            if1.in_valid = 1; if1.in_data = v16;
            @(posedge clk); #1;
        end
        if1.in_valid = 0;
        chk("w16_rand_sum", if1.out_sum, ref_sum);

        // WIDTH=4, N=2
        rst_n = 0; @(posedge clk); #1; rst_n = 1;
        if2.in_valid = 1; if2.in_data = 4'd7; @(posedge clk); #1;
        if2.in_data = 4'd9; @(posedge clk); #1;
        if2.in_valid = 0;
        chk("w4_vld", if2.out_valid, 1);
        chk("w4_sum", if2.out_sum, 0);
        @(posedge clk); #1;
        ref_sum = 0;
        for (int i = 0; i < 2; i++) begin
            v4 = 4'($urandom);
            ref_sum = (ref_sum + int'(v4)) % 16;
            if2.in_valid = 1; if2.in_data = v4;
            @(posedge clk); #1;
        end
        if2.in_valid = 0;
        chk("w4_rand_sum", if2.out_sum, ref_sum);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_accum.md
STREAM_ACCUM -- requirements
Module: stream_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of each input value and of the sum.
REQ-002 The block SHALL have parameter N, default 4, giving the number of input values per group; legal N >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous abort of the current group.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a value offered for accumulation.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a value this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: unsigned input value.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_sum holds a completed group sum.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_sum this cycle.
REQ-011 The block SHALL have port out_sum, output, WIDTH bits: sum of the N values of the group, modulo 2^WIDTH.

Function
REQ-012 The block SHALL implement a two-state FSM: ACCUM (collecting inputs) and HOLD (presenting the result).
REQ-013 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-014 An input transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-015 On each input transfer, the accumulator SHALL become (acc + in_data) mod 2^WIDTH, and the count SHALL increment by 1.
REQ-016 On the transfer with count = N-1, the FSM SHALL go to HOLD, out_sum SHALL take the final wrapped sum, and the count and accumulator SHALL return to 0.
REQ-017 out_valid SHALL rise exactly one cycle after the N-th input transfer.
REQ-018 In HOLD, out_sum SHALL remain stable until the handshake completes.
REQ-019 An output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; the FSM SHALL then return to ACCUM on the next cycle.
REQ-020 Input stalls (in_valid=0) SHALL leave the accumulator and count unchanged in any cycle.
REQ-021 Output stalls (out_ready=0) SHALL leave the FSM in HOLD for any number of cycles.
REQ-022 With in_valid and out_ready held at 1, throughput SHALL be one group every N+1 cycles.
REQ-023 clear=1 SHALL, in either state, move the FSM to ACCUM with accumulator=0, count=0 and out_valid=0 on the next cycle.
REQ-024 When clear coincides with an input transfer or an output transfer, clear SHALL win and any data in that transfer SHALL be discarded.
REQ-025 The count register SHALL be $clog2(N) bits wide and SHALL never exceed N-1.

Reset
REQ-026 While rst_n=0 at a rising clk edge, the block SHALL enter state ACCUM with accumulator=0, count=0, out_sum=0 and out_valid=0; in_ready SHALL be 1 after that edge.
REQ-027 Reset asserted mid-group or in HOLD SHALL discard all partial or pending results; rst_n SHALL take priority over clear and over all handshakes.

Structure
REQ-028 The FSM state enum typedef (ACCUM, HOLD) SHALL be defined in shared package stream_accum_pkg.
REQ-029 The default WIDTH and N constants SHALL also be defined in stream_accum_pkg.
REQ-030 The count logic SHALL be a single sub-module mod_n_counter, with parameter N and inputs clk, rst_n, clr, inc, and outputs count and wrap.
REQ-031 All outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from inputs to outputs.

Verification
REQ-032 Basic group: WIDTH=8, N=4, inputs 10, 20, 30, 40 back-to-back with out_ready=1 -> out_valid for 1 cycle, out_sum=100, one cycle after the 4th transfer.
REQ-033 Wrap-around: inputs 200, 150, 100, 50 -> out_sum=244; inputs 255, 255, 255, 255 -> out_sum=252.
REQ-034 Backpressure: out_ready=0 for 5 cycles after a group -> in_ready=0 and out_sum stable for all 5 cycles; next group accepted only after out_ready=1.
REQ-035 Input gaps: inputs 1, 2, 3, 4 with in_valid deasserted 2 cycles between each -> out_sum=10.
REQ-036 Clear and reset: clear after 2 of 4 inputs, then inputs 5, 5, 5, 5 -> out_sum=20; the same sequence with rst_n=0 instead of clear -> identical result, and all outputs at their reset values during reset.
REQ-037 Parameter sweep: WIDTH=16, N=8, inputs 1000..1700 in steps of 100 -> out_sum=10800; WIDTH=4, N=2, inputs 7, 9 -> out_sum=0.
